calc_cmd_sequencer: RTL and testbench
=====================================

# calc_cmd_sequencer

Command sequencer between the I2C slave byte interface and the calculator ALU in the TinyTapeout I2C calculator. It parses a 3-byte write transaction (opcode, operand A, operand B) and launches the ALU with a one-cycle start pulse. It waits for completion with a timeout, then serves the 16-bit result and a status byte to I2C read transactions. It owns all calculator sequencing; the ALU and I2C slave contain no command state.

## Interface
- TIMEOUT_CYCLES, 255: max cycles in EXEC before abort (8-bit counter, 1..255).
- NUM_OPS, 6: valid opcodes are 0..NUM_OPS-1.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- rx_start  in  1  one-cycle pulse on I2C START or repeated START addressed to us.
- rx_stop  in  1  one-cycle pulse on I2C STOP.
- rx_valid  in  1  one-cycle pulse: rx_data holds a received write byte.
- rx_data  in  8  received byte.
- tx_req  in  1  one-cycle pulse: master consumed tx_data, advance to next byte.
- tx_data  out  8  byte presented for the next master read (registered).
- alu_start  out  1  one-cycle launch pulse.
- alu_op  out  3  opcode, held stable from alu_start until done/timeout.
- alu_a, alu_b  out  8 each  operands, held stable likewise.
- alu_done  in  1  one-cycle pulse: alu_result valid.
- alu_result  in  16  ALU result.
- busy  out  1  high in GET_A, GET_B, EXEC.

## Operation
- States: IDLE, GET_A, GET_B, EXEC, DONE.
- Status byte: {busy, done_flag, err_op, err_timeout, overrun, err_short, 2'b00}.
- IDLE/DONE + rx_valid: latch opcode into alu_op. If opcode >= NUM_OPS, set err_op and stay/return IDLE. Otherwise clear all flags and go to GET_A.
- GET_A + rx_valid: latch alu_a, go to GET_B.
- GET_B + rx_valid: latch alu_b, go to EXEC, assert alu_start next cycle, load timeout counter.
- GET_A/GET_B + rx_stop or rx_start: set err_short, go to IDLE, ALU not started.
- EXEC + alu_done: capture alu_result into result register, set done_flag, go to DONE.
- EXEC timeout: counter reaches 0 without alu_done. Set err_timeout, go to IDLE, result register unchanged.
- EXEC + rx_valid: byte ignored, set overrun; sequence continues.
- DONE + rx_valid: treated as a new opcode byte (same as IDLE).
- Read pointer (2 bits) is reset to 0 on every rx_start.
  - ptr 0 → tx_data = result[15:8].
  - ptr 1 → tx_data = result[7:0].
  - ptr ≥ 2 → status byte; ptr saturates at 2.
  - tx_req increments ptr.
- Reads in any state return the current result register and live status; they never change state.

## Timing
- Reset values:
  - State: IDLE.
  - alu_start: 0.
  - alu_op, alu_a, alu_b: 0.
  - Result register: 0.
  - All flags: 0.
  - busy: 0.
  - Read pointer: 0.
  - tx_data: 0x00.
- Latency:
  - rx_valid of byte B in cycle N → alu_start high in cycle N+1 only.
  - alu_done in cycle M → state DONE and result registered in cycle M+1; tx_data reflects the new result in M+1 if ptr is 0 or 1.
- tx_req in cycle N → tx_data shows the next byte in cycle N+1.
- rx_start and rx_valid in the same cycle: start is processed first (byte counter and read pointer reset), then the byte is taken as an opcode.
- alu_done in the same cycle as timeout expiry: done wins, no err_timeout.
- rx_stop in the same cycle as rx_valid of byte B: byte B is accepted and EXEC entered; the stop is ignored.
- Timeout counts EXEC cycles starting with the alu_start cycle. alu_done arriving on cycle TIMEOUT_CYCLES is accepted.
- Asynchronous reset mid-EXEC: immediate return to reset values. A later alu_done is ignored because the state is IDLE.
- alu_done outside EXEC: ignored.

## Test plan
- Write op=0 (add), A=0x12, B=0x34; ALU returns 0x0046 after 3 cycles.
  - alu_start is a single pulse the cycle after byte B.
  - Reads return 0x00, 0x46, then status 0x40.
- Write opcode 0x07 with NUM_OPS=6: err_op set, no alu_start, status read = 0x20.
- Write op=1, A=0x05, then rx_stop: err_short set, state IDLE, status = 0x04, result unchanged.
- Full command with alu_done withheld: after 255 EXEC cycles err_timeout is set and state is IDLE (status 0x10). Then alu_done pulses: no change.
- Extra rx_valid during EXEC: overrun set. With alu_done and the timeout edge in the same cycle: DONE, status 0x48.
- Assert rst_n low mid-EXEC: all outputs return to reset values within the same cycle. A subsequent full command works normally.

Source files
------------

// File: rtl/calc_cmd_sequencer.sv
// ============================================================================
// Module   : calc_cmd_sequencer
// Brief    : Parses opcode/A/B write bytes, launches the ALU with a timeout
//            and serves the 16-bit result and status to I2C reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module calc_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int NUM_OPS        = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_start,
    input  logic        rx_stop,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_req,
    output logic [7:0]  tx_data,
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        busy
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_get_a = 3'd1;
    localparam logic [2:0] c_st_get_b = 3'd2;
    localparam logic [2:0] c_st_exec  = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    localparam logic [7:0] c_timeout  = 8'(TIMEOUT_CYCLES);
    localparam logic [8:0] c_num_ops  = 9'(NUM_OPS);
    localparam logic [1:0] c_ptr_stat = 2'd2;

    logic [2:0]  r_state,       w_state;
    logic        r_alu_start,   w_alu_start;
    logic [2:0]  r_alu_op,      w_alu_op;
    logic [7:0]  r_alu_a,       w_alu_a;
    logic [7:0]  r_alu_b,       w_alu_b;
    logic [15:0] r_result,      w_result;
    logic        r_done_flag,   w_done_flag;
    logic        r_err_op,      w_err_op;
    logic        r_err_timeout, w_err_timeout;
    logic        r_overrun,     w_overrun;
    logic        r_err_short,   w_err_short;
    logic [1:0]  r_ptr,         w_ptr;
    logic [7:0]  r_cnt,         w_cnt;
    logic [7:0]  r_tx_data,     w_tx_data;
    logic        w_busy;
    logic [7:0]  w_status;

    always_comb begin
        w_state       = r_state;
        w_alu_start   = 1'b0;
        w_alu_op      = r_alu_op;
        w_alu_a       = r_alu_a;
        w_alu_b       = r_alu_b;
        w_result      = r_result;
        w_done_flag   = r_done_flag;
        w_err_op      = r_err_op;
        w_err_timeout = r_err_timeout;
        w_overrun     = r_overrun;
        w_err_short   = r_err_short;
        w_ptr         = r_ptr;
        w_cnt         = r_cnt;

        // A START aborts a partial command before any byte in the same cycle
        // is looked at, so that byte is then parsed as a fresh opcode.
        if (rx_start) begin
            w_ptr = 2'd0;
            if (r_state == c_st_get_a || r_state == c_st_get_b) begin
                w_err_short = 1'b1;
                w_state     = c_st_idle;
            end
        end else if (tx_req && r_ptr < c_ptr_stat) begin
            w_ptr = r_ptr + 2'd1;
        end

        case (w_state)
            c_st_idle, c_st_done: begin
                if (rx_valid) begin
                    w_alu_op = rx_data[2:0];
                    if ({1'b0, rx_data} >= c_num_ops) begin
                        w_err_op = 1'b1;
                        w_state  = c_st_idle;
                    end else begin
                        w_done_flag   = 1'b0;
                        w_err_op      = 1'b0;
                        w_err_timeout = 1'b0;
                        w_overrun     = 1'b0;
                        w_err_short   = 1'b0;
                        w_state       = c_st_get_a;
                    end
                end
            end
            c_st_get_a: begin
                if (rx_valid) begin
                    w_alu_a = rx_data;
                    w_state = c_st_get_b;
                end else if (rx_stop) begin
                    w_err_short = 1'b1;
                    w_state     = c_st_idle;
                end
            end
            c_st_get_b: begin
                if (rx_valid) begin
                    w_alu_b     = rx_data;
                    w_alu_start = 1'b1;
                    w_cnt       = c_timeout;
                    w_state     = c_st_exec;
                end else if (rx_stop) begin
                    w_err_short = 1'b1;
                    w_state     = c_st_idle;
                end
            end
            c_st_exec: begin
                if (rx_valid) begin
                    w_overrun = 1'b1;
                end
                // Counter holds the EXEC cycles left including this one; a
                // done in the last allowed cycle still beats the timeout.
                if (alu_done) begin
                    w_result    = alu_result;
                    w_done_flag = 1'b1;
                    w_state     = c_st_done;
                end else if (r_cnt <= 8'd1) begin
                    w_err_timeout = 1'b1;
                    w_state       = c_st_idle;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state = c_st_idle;
            end
        endcase

        w_busy   = (w_state == c_st_get_a) || (w_state == c_st_get_b) ||
                   (w_state == c_st_exec);
        w_status = {w_busy, w_done_flag, w_err_op, w_err_timeout,
                    w_overrun, w_err_short, 2'b00};

        case (w_ptr)
            2'd0:    w_tx_data = w_result[15:8];
            2'd1:    w_tx_data = w_result[7:0];
            default: w_tx_data = w_status;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_alu_start   <= 1'b0;
            r_alu_op      <= 3'd0;
            r_alu_a       <= 8'd0;
            r_alu_b       <= 8'd0;
            r_result      <= 16'd0;
            r_done_flag   <= 1'b0;
            r_err_op      <= 1'b0;
            r_err_timeout <= 1'b0;
            r_overrun     <= 1'b0;
            r_err_short   <= 1'b0;
            r_ptr         <= 2'd0;
            r_cnt         <= 8'd0;
            r_tx_data     <= 8'd0;
        end else begin
            r_state       <= w_state;
            r_alu_start   <= w_alu_start;
            r_alu_op      <= w_alu_op;
            r_alu_a       <= w_alu_a;
            r_alu_b       <= w_alu_b;
            r_result      <= w_result;
            r_done_flag   <= w_done_flag;
            r_err_op      <= w_err_op;
            r_err_timeout <= w_err_timeout;
            r_overrun     <= w_overrun;
            r_err_short   <= w_err_short;
            r_ptr         <= w_ptr;
            r_cnt         <= w_cnt;
            r_tx_data     <= w_tx_data;
        end
    end

    assign tx_data   = r_tx_data;
    assign alu_start = r_alu_start;
    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign busy      = (r_state == c_st_get_a) || (r_state == c_st_get_b) ||
                       (r_state == c_st_exec);

endmodule

`default_nettype wire

// File: tb/tb_calc_cmd_sequencer.sv
// ============================================================================
// Module   : tb_calc_cmd_sequencer
// Brief    : Directed and random checks of calc_cmd_sequencer against a
//            command-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_calc_cmd_sequencer;

    localparam int TIMEOUT_CYCLES = 255;
    localparam int NUM_OPS        = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_start, rx_stop, rx_valid, tx_req, alu_done;
    logic [7:0]  rx_data;
    logic [15:0] alu_result;
    logic [7:0]  tx_data, alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_start, busy;

    always #5 clk = ~clk;

    calc_cmd_sequencer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .NUM_OPS       (NUM_OPS)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_start  (rx_start),
        .rx_stop   (rx_stop),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .alu_start (alu_start),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_done  (alu_done),
        .alu_result(alu_result),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: m_got counts command bytes taken (3 = ALU running),
    // m_age counts cycles the ALU has been running.
    int          m_got, m_age, m_ptr;
    logic [2:0]  m_op;
    logic [7:0]  m_a, m_b;
    logic [15:0] m_res;
    bit          m_done, m_eop, m_eto, m_ovr, m_esh, m_start;
    int          pend;

    function automatic logic [7:0] m_status();
        return {m_got != 0, m_done, m_eop, m_eto, m_ovr, m_esh, 2'b00};
    endfunction

    function automatic logic [7:0] m_tx();
        if (m_ptr == 0)      return m_res[15:8];
        else if (m_ptr == 1) return m_res[7:0];
        else                 return m_status();
    endfunction

    task automatic model_reset();
        m_got = 0; m_age = 0; m_ptr = 0; m_op = '0; m_a = '0; m_b = '0;
        m_res = '0; m_done = 0; m_eop = 0; m_eto = 0; m_ovr = 0; m_esh = 0;
        m_start = 0;
    endtask

    task automatic model_step(input bit s, p, v, input logic [7:0] d,
                              input bit t, dn, input logic [15:0] r);
        m_start = 0;
        if (s) begin
            m_ptr = 0;
            if (m_got == 1 || m_got == 2) begin m_esh = 1; m_got = 0; end
        end else if (t && m_ptr < 2) begin
            m_ptr++;
        end
        if (m_got == 3) begin
            if (v) m_ovr = 1;
            m_age++;
            if (dn) begin
                m_res = r; m_done = 1; m_got = 0;
            end else if (m_age >= TIMEOUT_CYCLES) begin
                m_eto = 1; m_got = 0;
            end
        end else if (v) begin
            case (m_got)
                0: begin
                    m_op = d[2:0];
                    if (d >= NUM_OPS) m_eop = 1;
                    else begin
                        m_done = 0; m_eop = 0; m_eto = 0; m_ovr = 0; m_esh = 0;
                        m_got = 1;
                    end
                end
                1: begin m_a = d; m_got = 2; end
                default: begin m_b = d; m_got = 3; m_age = 0; m_start = 1; end
            endcase
        end else if (p && (m_got == 1 || m_got == 2)) begin
            m_esh = 1; m_got = 0;
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ":tx_data"},   tx_data,   m_tx());
        check({ctx, ":busy"},      busy,      m_got != 0);
        check({ctx, ":alu_start"}, alu_start, m_start);
        check({ctx, ":alu_op"},    alu_op,    m_op);
        check({ctx, ":alu_a"},     alu_a,     m_a);
        check({ctx, ":alu_b"},     alu_b,     m_b);
    endtask

    // Called at a falling edge: drive one cycle, advance the model, check.
    task automatic tick(input string ctx, input bit s, p, v, input logic [7:0] d,
                        input bit t, dn, input logic [15:0] r);
        rx_start = s; rx_stop = p; rx_valid = v; rx_data = d;
        tx_req = t; alu_done = dn; alu_result = r;
        model_step(s, p, v, d, t, dn, r);
        @(negedge clk);
        check_all(ctx);
    endtask

    task automatic idle(input string ctx);
        tick(ctx, 0, 0, 0, 8'h00, 0, 0, 16'h0);
    endtask

    task automatic wr(input string ctx, input logic [7:0] d);
        tick(ctx, 0, 0, 1, d, 0, 0, 16'h0);
    endtask

    task automatic rd(input string ctx);
        tick(ctx, 0, 0, 0, 8'h00, 1, 0, 16'h0);
    endtask

    task automatic do_reset();
        rx_start = 0; rx_stop = 0; rx_valid = 0; rx_data = 0;
        tx_req = 0; alu_done = 0; alu_result = 0;
        rst_n = 1'b0;
        model_reset();
        pend = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all("reset");
    endtask

    initial begin
        do_reset();
        check("rst_tx", tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);

        // Basic add command, ALU answers in the third EXEC cycle
        wr("t1", 8'h00); wr("t1", 8'h12); wr("t1", 8'h34);
        check("t1_start_hi", alu_start, 1'b1);
        check("t1_a", alu_a, 8'h12);
        check("t1_b", alu_b, 8'h34);
        idle("t1");
        check("t1_start_lo", alu_start, 1'b0);
        idle("t1");
        tick("t1", 0, 0, 0, 8'h00, 0, 1, 16'h0046);
        check("t1_rd_hi", tx_data, 8'h00);
        rd("t1");
        check("t1_rd_lo", tx_data, 8'h46);
        rd("t1");
        check("t1_rd_stat", tx_data, 8'h40);
        rd("t1");
        check("t1_rd_sat", tx_data, 8'h40);

        // Short command aborted by STOP, result kept
        tick("t3", 1, 0, 0, 8'h00, 0, 0, 16'h0);
        wr("t3", 8'h01); wr("t3", 8'h05);
        tick("t3", 0, 1, 0, 8'h00, 0, 0, 16'h0);
        check("t3_busy", busy, 1'b0);
        tick("t3", 1, 0, 0, 8'h00, 0, 0, 16'h0);
        check("t3_rd_hi", tx_data, 8'h00);
        rd("t3");
        check("t3_rd_lo", tx_data, 8'h46);
        rd("t3");
        check("t3_rd_stat", tx_data, 8'h04);

        // Illegal opcode
        do_reset();
        wr("t2", 8'h07);
        check("t2_op", alu_op, 3'd7);
        idle("t2");
        rd("t2"); rd("t2");
        check("t2_stat", tx_data, 8'h20);

        // Timeout with ALU silent, late done ignored
        do_reset();
        wr("t4", 8'h02); wr("t4", 8'h11); wr("t4", 8'h22);
        for (int i = 1; i <= TIMEOUT_CYCLES; i++) begin
            tick("t4", 0, 0, 0, 8'h00, i <= 2, 0, 16'h0);
            if (i == TIMEOUT_CYCLES - 1) check("t4_busy_stat", tx_data, 8'h80);
        end
        check("t4_timeout_stat", tx_data, 8'h10);
        tick("t4", 0, 0, 0, 8'h00, 0, 1, 16'hBEEF);
        check("t4_late_done", tx_data, 8'h10);
        tick("t4", 1, 0, 0, 8'h00, 0, 0, 16'h0);
        check("t4_res_kept", tx_data, 8'h00);

        // Overrun, then done on the final allowed cycle
        do_reset();
        wr("t5", 8'h03); wr("t5", 8'h40); wr("t5", 8'h02);
        wr("t5", 8'h99);
        for (int i = 2; i < TIMEOUT_CYCLES; i++) idle("t5");
        tick("t5", 0, 0, 0, 8'h00, 0, 1, 16'h1234);
        check("t5_busy", busy, 1'b0);
        check("t5_rd_hi", tx_data, 8'h12);
        rd("t5");
        check("t5_rd_lo", tx_data, 8'h34);
        rd("t5");
        check("t5_stat", tx_data, 8'h48);

        // Asynchronous reset in the middle of EXEC
        wr("t6", 8'h04); wr("t6", 8'hAA); wr("t6", 8'h55);
        idle("t6"); idle("t6");
        #2 rst_n = 1'b0;
        #1;
        check("t6_op", alu_op, 3'd0);
        check("t6_a", alu_a, 8'h00);
        check("t6_b", alu_b, 8'h00);
        check("t6_busy", busy, 1'b0);
        check("t6_start", alu_start, 1'b0);
        check("t6_tx", tx_data, 8'h00);
        model_reset();
        pend = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick("t6", 0, 0, 0, 8'h00, 0, 1, 16'hFFFF);
        check("t6_done_ign", tx_data, 8'h00);
        wr("t6", 8'h01); wr("t6", 8'h10); wr("t6", 8'h20);
        idle("t6");
        tick("t6", 0, 0, 0, 8'h00, 0, 1, 16'h0030);
        rd("t6");
        check("t6_rd_lo", tx_data, 8'h30);
        rd("t6");
        check("t6_stat", tx_data, 8'h40);

        // Random traffic with a behavioural ALU of varying latency
        for (int i = 0; i < 6000; i++) begin
            bit s, p, v, t, dn;
            logic [7:0]  d;
            logic [15:0] r;
            if (m_start) begin
                int k;
                k = int'($urandom_range(0, 99));
                if (k < 60)      pend = int'($urandom_range(1, 6));
                else if (k < 75) pend = int'($urandom_range(253, 257));
                else if (k < 85) pend = 0;
                else             pend = int'($urandom_range(7, 40));
            end
            dn = (pend == 1) || (pend == 0 && $urandom_range(0, 99) < 3);
            if (pend > 0) pend--;
            s = $urandom_range(0, 99) < 3;
            p = $urandom_range(0, 99) < 3;
            v = $urandom_range(0, 99) < 30;
            t = !s && ($urandom_range(0, 99) < 20);
            d = $urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            r = 16'($urandom);
            tick("rand", s, p, v, d, t, dn, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
